data_mem_stage: RTL and testbench

Parametrised memory-access stage for the pipelined CPU. It replaces the fixed 8-byte, zero-latency data memory with a byte-addressed, little-endian store that has a valid/ready request handshake, a configurable read latency, 1/2/4/8-byte transfers with sign/zero extension, and misalignment detection. It sits between EX and WB and keeps the branch-taken resolution (B / CBZ). It drives a stall to the pipeline while a read is outstanding.

---
 rtl/mem_pkg.sv | 13 +
 rtl/data_mem_stage_load_extend.sv | 24 ++
 rtl/data_mem_stage.sv | 140 ++++++++++++++
 tb/tb_data_mem_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory stage: transfer sizes,
// FSM states and a size-to-byte-count helper.
package mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} xfer_size_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  function automatic logic [3:0] size_bytes(xfer_size_t sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/data_mem_stage_load_extend.sv
// Extracts the low 1/2/4/8 bytes of a little-endian read word and
// sign- or zero-extends them to the full data width.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw,
  input  xfer_size_t        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = {{(DATA_W-8){is_signed & raw[7]}}, raw[7:0]};
      SZ_H:    data = {{(DATA_W-16){is_signed & raw[15]}}, raw[15:0]};
      SZ_W:    data = {{(DATA_W-32){is_signed & raw[31]}}, raw[31:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// Byte-addressed little-endian data memory stage with valid/ready requests,
// fixed read latency and branch resolution. Optional MEM_PERF_CNT_EN adds load/store counters.
module data_mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic              zero,
  input  logic              branch,
  input  logic              cbz,
  output logic              br_taken,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              stall,
  output logic              misalign_err
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int NB = DATA_W / 8;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [7:0]        mem [DEPTH_BYTES];
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     ld_addr;
  xfer_size_t        ld_size;
  logic              ld_signed;
  logic              ld_misalign;
  logic              accept;
  logic              misaligned;
  xfer_size_t        req_sz;
  logic [3:0]        req_nbytes;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ext_data;
  logic              unused_addr_bits;

  assign req_sz     = xfer_size_t'(req_size);
  assign req_nbytes = size_bytes(req_sz);
  assign req_ready  = (state == IDLE);
  assign stall      = ~req_ready;
  assign accept     = req_valid & req_ready;
  assign misaligned = |(req_addr[2:0] & ~(3'b111 << req_size));
  assign br_taken   = (cbz & zero) | branch;
  assign unused_addr_bits = ^req_addr[ADDR_W-1:AW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      misalign_err <= 1'b0;
      ld_addr      <= '0;
      ld_size      <= SZ_B;
      ld_signed    <= 1'b0;
      ld_misalign  <= 1'b0;
    end else begin
      misalign_err <= accept & misaligned;
      case (state)
        IDLE: begin
          if (accept && !req_write) begin
            ld_addr     <= req_addr[AW-1:0];
            ld_size     <= req_sz;
            ld_signed   <= req_signed;
            ld_misalign <= misaligned;
            if (RD_LAT == 1) begin
              state <= RESP;
              cnt   <= '0;
            end else begin
              state <= RD_WAIT;
              cnt   <= CW'(RD_LAT - 1);
            end
          end
        end
        // Leave for RESP on the edge where the countdown reaches zero.
        RD_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && !misaligned) begin
      for (int i = 0; i < NB; i++) begin
        if (i < int'(req_nbytes)) mem[req_addr[AW-1:0] + AW'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) rd_word[8*i +: 8] = mem[ld_addr + AW'(i)];
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .raw       (rd_word),
    .size      (ld_size),
    .is_signed (ld_signed),
    .data      (ext_data)
  );

  assign resp_valid = (state == RESP);
  assign resp_rdata = (resp_valid && !ld_misalign) ? ext_data : '0;

`ifdef MEM_PERF_CNT_EN
  // Saturating counters of accepted requests, misaligned ones included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (accept) begin
      if (req_write) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed self-checking bench for data_mem_stage (default parameters, RD_LAT = 2).
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;
  logic        zero, branch, cbz, br_taken;
  logic        resp_valid, stall, misalign_err;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] rd_count, wr_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  data_mem_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .zero         (zero),
    .branch       (branch),
    .cbz          (cbz),
    .br_taken     (br_taken),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .stall        (stall),
    .misalign_err (misalign_err)
`ifdef MEM_PERF_CNT_EN
    ,
    .rd_count     (rd_count),
    .wr_count     (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [1:0] size, input logic sgn);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_size   = size;
    req_signed = sgn;
  endtask

  task automatic do_store(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input logic exp_mis);
    apply_stimulus(1'b1, addr, wdata, size, 1'b0);
    step();
    req_valid = 1'b0;
    exp_wr++;
    check_output({tag, "_mis"}, 64'(misalign_err), 64'(exp_mis));
    check_output({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  // Load with RD_LAT = 2: RD_WAIT in the cycle after acceptance, RESP in the next.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic exp_mis, input logic [63:0] exp_data);
    apply_stimulus(1'b0, addr, 64'h0, size, sgn);
    step();
    req_valid = 1'b0;
    exp_rd++;
    check_output({tag, "_stall1"}, 64'(stall), 64'd1);
    check_output({tag, "_mis"}, 64'(misalign_err), 64'(exp_mis));
    check_output({tag, "_early"}, 64'(resp_valid), 64'd0);
    step();
    check_output({tag, "_valid"}, 64'(resp_valid), 64'd1);
    check_output({tag, "_data"}, resp_rdata, exp_data);
    check_output({tag, "_stall2"}, 64'(stall), 64'd1);
    check_output({tag, "_mis_clr"}, 64'(misalign_err), 64'd0);
    step();
    check_output({tag, "_done"}, 64'(resp_valid), 64'd0);
    check_output({tag, "_ready"}, 64'(req_ready), 64'd1);
    check_output({tag, "_rd_zero"}, resp_rdata, 64'd0);
  endtask

  task automatic check_branch(input string tag, input logic z, input logic c, input logic b,
                              input logic exp);
    zero = z;
    cbz = c;
    branch = b;
    #1;
    check_output(tag, 64'(br_taken), 64'(exp));
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_signed = 1'b0;
    zero = 1'b0; branch = 1'b0; cbz = 1'b0;
    step();
    step();
    check_output("rst_ready", 64'(req_ready), 64'd1);
    check_output("rst_valid", 64'(resp_valid), 64'd0);
    check_output("rst_mis", 64'(misalign_err), 64'd0);
    check_output("rst_stall", 64'(stall), 64'd0);
    check_output("rst_rdata", resp_rdata, 64'd0);
    reset_n = 1'b1;
    step();

    $display("[TB] full-width store and load");
    do_store("st_d", 64'h10, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
    do_load("ld_d", 64'h10, 2'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7788);

    $display("[TB] sub-word loads with extension");
    do_store("st_b", 64'h10, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b0);
    do_load("ld_bs", 64'h10, 2'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("ld_bu", 64'h10, 2'd0, 1'b0, 1'b0, 64'h0000_0000_0000_0080);
    do_load("ld_hs", 64'h10, 2'd1, 1'b1, 1'b0, 64'h0000_0000_0000_7780);
    do_load("ld_ws", 64'h14, 2'd2, 1'b1, 1'b0, 64'h0000_0000_1122_3344);

    $display("[TB] misalignment");
    do_store("st_mis", 64'h13, 64'h0000_0000_DEAD_BEEF, 2'd2, 1'b1);
    do_load("ld_unch", 64'h10, 2'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7780);
    do_load("ld_mis", 64'h11, 2'd1, 1'b1, 1'b1, 64'h0);

    $display("[TB] address wrap and boundaries");
    do_store("st_wrap", 64'h420, 64'hCAFE_F00D_DEAD_BEEF, 2'd3, 1'b0);
    do_load("ld_wrap", 64'h20, 2'd3, 1'b0, 1'b0, 64'hCAFE_F00D_DEAD_BEEF);
    do_load("ld_w_neg", 64'h20, 2'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);
    do_load("ld_h_neg", 64'h22, 2'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_DEAD);
    do_load("ld_wu", 64'h24, 2'd2, 1'b0, 1'b0, 64'h0000_0000_CAFE_F00D);
    do_load("ld_hi_addr", 64'hFFFF_0000_0000_0027, 2'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFCA);
    do_store("st_last", 64'h3F8, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0);
    do_load("ld_last", 64'h3F8, 2'd3, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);

    $display("[TB] back-to-back stores");
    apply_stimulus(1'b1, 64'h30, 64'hA5A5_0000_1111_2222, 2'd3, 1'b0);
    step();
    check_output("b2b_ready", 64'(req_ready), 64'd1);
    apply_stimulus(1'b1, 64'h38, 64'h5A5A_3333_4444_5555, 2'd3, 1'b0);
    step();
    req_valid = 1'b0;
    exp_wr += 2;
    check_output("b2b_ready2", 64'(req_ready), 64'd1);
    do_load("ld_b2b0", 64'h30, 2'd3, 1'b0, 1'b0, 64'hA5A5_0000_1111_2222);
    do_load("ld_b2b1", 64'h38, 2'd3, 1'b0, 1'b0, 64'h5A5A_3333_4444_5555);

`ifdef MEM_PERF_CNT_EN
    check_output("rd_count", 64'(rd_count), 64'(exp_rd));
    check_output("wr_count", 64'(wr_count), 64'(exp_wr));
`endif

    $display("[TB] reset during an outstanding load");
    apply_stimulus(1'b0, 64'h20, 64'h0, 2'd3, 1'b0);
    step();
    req_valid = 1'b0;
    check_output("rst_ld_stall", 64'(stall), 64'd1);
    reset_n = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    #1;
    check_output("rst_mid_ready", 64'(req_ready), 64'd1);
    check_output("rst_mid_valid", 64'(resp_valid), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("rst_no_resp", 64'(resp_valid), 64'd0);
      check_output("rst_idle", 64'(req_ready), 64'd1);
    end
`ifdef MEM_PERF_CNT_EN
    check_output("rd_count_rst", 64'(rd_count), 64'd0);
`endif
    do_load("ld_after_rst", 64'h20, 2'd3, 1'b0, 1'b0, 64'hCAFE_F00D_DEAD_BEEF);
`ifdef MEM_PERF_CNT_EN
    check_output("rd_count_post", 64'(rd_count), 64'(exp_rd));
    check_output("wr_count_post", 64'(wr_count), 64'(exp_wr));
`endif

    $display("[TB] branch resolution");
    check_branch("br_cbz_z", 1'b1, 1'b1, 1'b0, 1'b1);
    check_branch("br_cbz_nz", 1'b0, 1'b1, 1'b0, 1'b0);
    check_branch("br_uncond", 1'b0, 1'b0, 1'b1, 1'b1);
    check_branch("br_zero_only", 1'b1, 1'b0, 1'b0, 1'b0);
    check_branch("br_none", 1'b0, 1'b0, 1'b0, 1'b0);
    check_branch("br_all", 1'b1, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
